// File: rtl/dshot_pkg.sv
// Shared DShot definitions used by the receive-side decoder and the transmitter.
//   DSHOT_FRAME_BITS    : bits per frame (MSB first)
//   DSHOT_THROTTLE_BITS : throttle field width, frame[15:5]
//   DSHOT_CRC_BITS      : CRC field width, frame[3:0]
//   dshot_rx_state_t    : receiver FSM state
//   dshot_crc()         : 4-bit nibble-XOR CRC over frame[15:4]
package dshot_pkg;

  localparam int unsigned DSHOT_FRAME_BITS    = 16;
  localparam int unsigned DSHOT_THROTTLE_BITS = 11;
  localparam int unsigned DSHOT_CRC_BITS      = 4;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StHigh,
    StLow
  } dshot_rx_state_t;

  // XOR of the three nibbles of throttle+telemetry; same as (v ^ v>>4 ^ v>>8) & 4'hF.
  function automatic logic [DSHOT_CRC_BITS-1:0] dshot_crc(input logic [11:0] v);
    return v[3:0] ^ v[7:4] ^ v[11:8];
  endfunction

endpackage

// File: rtl/dshot_decoder_if.sv
// DShot receive bundle: the raw line in, decoded frame results out.
//   i_dshot     : raw DShot line (asynchronous to the system clock)
//   o_throttle  : last accepted throttle value
//   o_telemetry : last accepted telemetry-request bit
//   o_valid     : one-cycle strobe, frame accepted
//   o_crc_err   : one-cycle strobe, complete frame failed CRC
//   o_frame_err : one-cycle strobe, timing violation or truncated frame
// modport master: line driver / result consumer; modport slave: the decoder.
interface dshot_decoder_if;
  import dshot_pkg::*;

  logic                           i_dshot;
  logic [DSHOT_THROTTLE_BITS-1:0] o_throttle;
  logic                           o_telemetry;
  logic                           o_valid;
  logic                           o_crc_err;
  logic                           o_frame_err;

  modport master (
    output i_dshot,
    input  o_throttle,
    input  o_telemetry,
    input  o_valid,
    input  o_crc_err,
    input  o_frame_err
  );

  modport slave (
    input  i_dshot,
    output o_throttle,
    output o_telemetry,
    output o_valid,
    output o_crc_err,
    output o_frame_err
  );

endinterface

// File: rtl/dshot_edge_sync.sv
// Two-flop synchronizer for the DShot line plus rise/fall detection.
//   i_clk, i_rst_n : system clock, asynchronous active-low reset
//   i_dshot        : raw asynchronous line
//   s_in           : synchronized line (2 cycles after the pin)
//   o_rise, o_fall : asserted in the first cycle s_in shows the new level
module dshot_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_dshot,
  output logic s_in,
  output logic o_rise,
  output logic o_fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= i_dshot;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign s_in   = sync_q;
  assign o_rise = sync_q & ~prev_q;
  assign o_fall = ~sync_q & prev_q;

endmodule

// File: rtl/dshot_decoder.sv
// DShot frame receiver: recovers throttle, telemetry bit and CRC status from the line.
//   BIT_CLKS : system clocks per DShot bit (83 = DShot600 at 50 MHz)
//   GAP_CLKS : minimum low time between frames that arms the receiver
//   i_clk, i_rst_n : system clock, asynchronous active-low reset
//   bus      : dshot_decoder_if.slave (line in, results and strobes out)
// Build option: define DSHOT_DECODER_CRC_CHECK_EN to check the CRC; otherwise every
// complete frame is accepted and o_crc_err is tied low.
module dshot_decoder
  import dshot_pkg::*;
#(
  parameter int unsigned BIT_CLKS = 83,
  parameter int unsigned GAP_CLKS = 166
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  dshot_decoder_if.slave bus
);

  localparam int unsigned CntW = $clog2(GAP_CLKS + 1);
  localparam int unsigned IdxW = $clog2(DSHOT_FRAME_BITS);
  // Only the first 15 bits are stored; the 16th is used straight from the comparator.
  localparam int unsigned ShW  = DSHOT_FRAME_BITS - 1;

  localparam logic [CntW-1:0] GapMax  = CntW'(GAP_CLKS);
  localparam logic [CntW-1:0] BitMax  = CntW'(BIT_CLKS);
  localparam logic [CntW-1:0] Thresh  = CntW'(BIT_CLKS / 2);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DSHOT_FRAME_BITS - 1);

  logic s_in;
  logic rise;
  logic fall;

  dshot_edge_sync u_edge_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_dshot (bus.i_dshot),
    .s_in    (s_in),
    .o_rise  (rise),
    .o_fall  (fall)
  );

  dshot_rx_state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [ShW-1:0]  shift_q, shift_d;

  logic [CntW-1:0] cnt_inc;
  logic            bit_val;
  logic            done;
  logic            frame_err;

  // One counter serves as gap, high and low counter; only one is live per state.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign bit_val = (cnt_q > Thresh);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    done      = 1'b0;
    frame_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s_in) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= GapMax) state_d = StArmed;
        end
      end
      StArmed: begin
        if (rise) begin
          state_d = StHigh;
          cnt_d   = '0;
          idx_d   = '0;
          shift_d = '0;
        end
      end
      StHigh: begin
        cnt_d = cnt_inc;
        if (fall) begin
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            done    = 1'b1;
            state_d = StIdle;
          end else begin
            shift_d = {shift_q[ShW-2:0], bit_val};
            state_d = StLow;
          end
        end else if (cnt_inc >= BitMax) begin
          frame_err = 1'b1;
          cnt_d     = '0;
          state_d   = StIdle;
        end
      end
      StLow: begin
        cnt_d = cnt_inc;
        if (rise) begin
          cnt_d   = '0;
          state_d = StHigh;
        end else if (cnt_inc >= BitMax) begin
          frame_err = 1'b1;
          cnt_d     = '0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Frame fields at completion: shift_q holds frame[15:1], bit_val is frame[0].
  logic [DSHOT_THROTTLE_BITS-1:0] rx_throttle;
  logic                           rx_telemetry;

  assign rx_throttle  = shift_q[ShW-1 -: DSHOT_THROTTLE_BITS];
  assign rx_telemetry = shift_q[ShW-1-DSHOT_THROTTLE_BITS];

  logic [DSHOT_THROTTLE_BITS-1:0] throttle_q, throttle_d;
  logic                           telemetry_q, telemetry_d;
  logic                           valid_q, valid_d;
  logic                           frame_err_q;
  logic                           crc_err_d;

`ifdef DSHOT_DECODER_CRC_CHECK_EN
  logic crc_ok;
  logic crc_err_q;

  assign crc_ok = (dshot_crc(shift_q[ShW-1 -: 12]) == {shift_q[DSHOT_CRC_BITS-2:0], bit_val});
`endif

  always_comb begin
    throttle_d  = throttle_q;
    telemetry_d = telemetry_q;
    valid_d     = 1'b0;
    crc_err_d   = 1'b0;
    if (done) begin
`ifdef DSHOT_DECODER_CRC_CHECK_EN
      if (crc_ok) begin
        valid_d     = 1'b1;
        throttle_d  = rx_throttle;
        telemetry_d = rx_telemetry;
      end else begin
        crc_err_d = 1'b1;
      end
`else
      valid_d     = 1'b1;
      throttle_d  = rx_throttle;
      telemetry_d = rx_telemetry;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      throttle_q  <= '0;
      telemetry_q <= 1'b0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      throttle_q  <= throttle_d;
      telemetry_q <= telemetry_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err;
    end
  end

`ifdef DSHOT_DECODER_CRC_CHECK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      crc_err_q <= 1'b0;
    end else begin
      crc_err_q <= crc_err_d;
    end
  end

  assign bus.o_crc_err = crc_err_q;
`else
  assign bus.o_crc_err = crc_err_d & 1'b0;
`endif

  assign bus.o_throttle  = throttle_q;
  assign bus.o_telemetry = telemetry_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_frame_err = frame_err_q;

endmodule

// File: tb/tb_dshot_decoder.sv
// Self-checking bench for dshot_decoder: directed frames from the test plan plus
// randomized frames scored against a frame-level reference model.
`timescale 1ns / 1ps
module tb_dshot_decoder;

`ifdef DSHOT_DECODER_CRC_CHECK_EN
  localparam bit CrcEn = 1'b1;
`else
  localparam bit CrcEn = 1'b0;
`endif
  localparam int BitClks = 83;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dshot_decoder_if bus ();

  dshot_decoder #(
    .BIT_CLKS (83),
    .GAP_CLKS (166)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Strobe monitor.
  int n_valid = 0, n_crc = 0, n_ferr = 0;
  int last_valid_cyc = 0, last_ferr_cyc = 0;
  int excl_bad = 0, glitch = 0;
  logic [10:0] prev_thr = '0;
  logic        prev_tel = 1'b0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.o_valid === 1'b1) begin n_valid++; last_valid_cyc = cyc; end
      if (bus.o_crc_err === 1'b1) n_crc++;
      if (bus.o_frame_err === 1'b1) begin n_ferr++; last_ferr_cyc = cyc; end
      if ($countones({bus.o_valid, bus.o_crc_err, bus.o_frame_err}) > 1) excl_bad++;
      if ((bus.o_throttle !== prev_thr || bus.o_telemetry !== prev_tel) && bus.o_valid !== 1'b1)
        glitch++;
    end
    prev_thr = bus.o_throttle;
    prev_tel = bus.o_telemetry;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: CRC from the frame rules, plain integer arithmetic.
  function automatic int ref_crc(input int v12);
    return (v12 ^ (v12 >> 4) ^ (v12 >> 8)) & 15;
  endfunction

  function automatic logic [15:0] mk_frame(input int thr, input int tel);
    int v;
    v = thr * 2 + tel;
    return 16'(v * 16 + ref_crc(v));
  endfunction

  int exp_thr = 0;
  int exp_tel = 0;
  int v0, c0, f0;

  task automatic snap();
    v0 = n_valid; c0 = n_crc; f0 = n_ferr;
  endtask

  task automatic expect_counts(input string tag, input int dv, input int dc, input int df);
    check({tag, "_valid_cnt"}, n_valid - v0, dv);
    check({tag, "_crc_cnt"}, n_crc - c0, dc);
    check({tag, "_ferr_cnt"}, n_ferr - f0, df);
  endtask

  task automatic idle_low(input int n);
    bus.i_dshot = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Sends the top nbits of f, each a full bit period; fall_cyc is the last high->low.
  task automatic send_frame(input logic [15:0] f, input int nbits, input int hi1,
                            input int hi0, output int fall_cyc);
    int hi;
    fall_cyc = 0;
    for (int i = 15; i > 15 - nbits; i--) begin
      hi = f[i] ? hi1 : hi0;
      bus.i_dshot = 1'b1;
      repeat (hi) @(negedge clk);
      bus.i_dshot = 1'b0;
      fall_cyc = cyc;
      repeat (BitClks - hi) @(negedge clk);
    end
  endtask

  task automatic run_frame(input string tag, input logic [15:0] f, input int hi1,
                           input int hi0, input int gap);
    int fall;
    bit good;
    snap();
    send_frame(f, 16, hi1, hi0, fall);
    idle_low(gap);
    good = !CrcEn || (ref_crc(int'(f >> 4)) == int'(f[3:0]));
    if (good) begin
      exp_thr = int'(f >> 5);
      exp_tel = int'(f[4]);
      expect_counts(tag, 1, 0, 0);
      check({tag, "_latency"}, last_valid_cyc - fall, 3);
    end else begin
      expect_counts(tag, 0, 1, 0);
    end
    check({tag, "_throttle"}, bus.o_throttle, exp_thr);
    check({tag, "_telemetry"}, bus.o_telemetry, exp_tel);
  endtask

  initial begin
    int fall;
    int rise_cyc;
    logic [15:0] f;
    int hi1, hi0;

    rst_n = 1'b0;
    bus.i_dshot = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_throttle", bus.o_throttle, 0);
    check("rst_telemetry", bus.o_telemetry, 0);
    check("rst_valid", bus.o_valid, 0);
    check("rst_crc_err", bus.o_crc_err, 0);
    check("rst_frame_err", bus.o_frame_err, 0);
    rst_n = 1'b1;
    idle_low(200);

    // Good frame, telemetry frame, CRC-corrupted frame.
    run_frame("good", 16'h82C6, 62, 31, 200);
    check("good_thr_1046", bus.o_throttle, 1046);
    run_frame("telem", 16'h0617, 62, 31, 200);
    check("telem_thr_48", bus.o_throttle, 48);
    check("telem_bit", bus.o_telemetry, 1);
    run_frame("badcrc", 16'h82C7, 62, 31, 200);
    check("badcrc_thr", bus.o_throttle, CrcEn ? 48 : 1046);

    // Stuck high after arming.
    snap();
    bus.i_dshot = 1'b1;
    rise_cyc = cyc;
    repeat (100) @(negedge clk);
    idle_low(200);
    expect_counts("stuck", 0, 0, 1);
    // Synchronized rise is 2 cycles after the pin; error ~83 clocks later.
    check("stuck_err_time",
          ((last_ferr_cyc - rise_cyc) >= 84 && (last_ferr_cyc - rise_cyc) <= 88), 1);
    check("stuck_throttle", bus.o_throttle, exp_thr);

    // Truncated frame, then a good frame after the gap.
    snap();
    send_frame(16'h0617, 10, 62, 31, fall);
    idle_low(150);
    expect_counts("trunc", 0, 0, 1);
    check("trunc_throttle", bus.o_throttle, exp_thr);
    idle_low(170);
    run_frame("after_trunc", 16'h0617, 62, 31, 200);

    // Back-to-back: second frame falls inside the gap and must be ignored.
    snap();
    send_frame(16'h82C6, 16, 62, 31, fall);
    idle_low(100);
    send_frame(16'h0617, 16, 62, 31, fall);
    idle_low(166);
    expect_counts("b2b", 1, 0, 0);
    check("b2b_throttle", bus.o_throttle, 1046);
    exp_thr = 1046;
    exp_tel = 0;
    run_frame("b2b_third", mk_frame(777, 1), 60, 30, 200);

    // Reset during bit 7.
    snap();
    send_frame(16'h82C6, 8, 62, 31, fall);
    bus.i_dshot = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_throttle", bus.o_throttle, 0);
    check("midrst_telemetry", bus.o_telemetry, 0);
    check("midrst_strobes", {bus.o_valid, bus.o_crc_err, bus.o_frame_err}, 0);
    bus.i_dshot = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle_low(200);
    expect_counts("midrst", 0, 0, 0);
    exp_thr = 0;
    exp_tel = 0;
    run_frame("after_rst", 16'h82C6, 62, 31, 200);

    // Randomized frames, some with corrupted CRC, jittered high times and gaps.
    for (int k = 0; k < 10; k++) begin
      f = mk_frame(int'($urandom_range(0, 2047)), int'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) f[3:0] = f[3:0] ^ 4'($urandom_range(1, 15));
      hi1 = int'($urandom_range(55, 68));
      hi0 = int'($urandom_range(24, 36));
      run_frame($sformatf("rand%0d", k), f, hi1, hi0, int'($urandom_range(170, 260)));
    end

    check("mutex_strobes", excl_bad, 0);
    check("outputs_stable", glitch, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
